// File: rtl/imem_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package imem_cache_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ICACHE_LOOKUP   = 2'd0,
        ICACHE_MISS_REQ = 2'd1,
        ICACHE_REFILL   = 2'd2,
        ICACHE_REPLAY   = 2'd3
    } icache_state_e;

    // Tag takes every address bit above the byte, offset and index fields.
    function automatic int tag_bits(input int num_lines, input int line_words);
        return ADDR_W - 2 - $clog2(num_lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// Synchronous-read RAM with one write port; used for both the tag and data stores.
module icache_data_array #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_cache.sv
// Direct-mapped instruction cache: 1-cycle hits, single-line refill over a
// valid/ready request channel and a beat-per-word response channel.
//
// state            | meaning
// ICACHE_LOOKUP    | accept fetches, compare tag of last accepted address
// ICACHE_MISS_REQ  | present line refill request until memory accepts it
// ICACHE_REFILL    | write incoming beats in ascending word order
// ICACHE_REPLAY    | re-read the refilled word; delivered the next cycle
module imem_cache
    import imem_cache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_req,
    input  logic              invalidate,
    output logic [WORD_W-1:0] inst,
    output logic              inst_valid,
    output logic              cache_stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [WORD_W-1:0] mem_resp_data
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = tag_bits(NUM_LINES, LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    icache_state_e      state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic               lookup_q, lookup_d;
    logic               replay_q, replay_d;
    logic               inv_pend_q, inv_pend_d;

    logic [OFF_W-1:0]   if_off;
    logic [IDX_W-1:0]   if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [TAG_W-1:0]   tag_rd;
    logic [WORD_W-1:0]  data_rd;
    logic               tag_match;
    logic               miss;
    logic               fill_we;
    logic               fill_last;
    logic               unused_byte_bits;

    assign if_off = if_addr[2 +: OFF_W];
    assign if_idx = if_addr[2 + OFF_W +: IDX_W];
    assign if_tag = if_addr[ADDR_W-1 -: TAG_W];
    assign unused_byte_bits = ^if_addr[1:0];

    assign tag_match = valid_q[idx_q] && (tag_rd == tag_q);
    assign miss      = (state_q == ICACHE_LOOKUP) && lookup_q && !replay_q && !tag_match;
    assign fill_we   = (state_q == ICACHE_REFILL) && mem_resp_valid;
    assign fill_last = fill_we && (cnt_q == LAST_BEAT);

    // Replay reads at the held address; otherwise the array follows the IF address.
    icache_data_array #(.DEPTH(NUM_LINES * LINE_WORDS), .WIDTH(WORD_W)) u_data (
        .clk   (clk),
        .we    (fill_we),
        .waddr ({idx_q, cnt_q}),
        .wdata (mem_resp_data),
        .raddr ((state_q == ICACHE_REPLAY) ? {idx_q, off_q} : {if_idx, if_off}),
        .rdata (data_rd)
    );

    icache_data_array #(.DEPTH(NUM_LINES), .WIDTH(TAG_W)) u_tag (
        .clk   (clk),
        .we    (fill_last),
        .waddr (idx_q),
        .wdata (tag_q),
        .raddr ((state_q == ICACHE_REPLAY) ? idx_q : if_idx),
        .rdata (tag_rd)
    );

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        inv_pend_d = inv_pend_q;
        lookup_d   = 1'b0;
        replay_d   = 1'b0;
        valid_d    = invalidate ? '0 : valid_q;

        case (state_q)
            ICACHE_LOOKUP: begin
                if (miss) begin
                    state_d    = ICACHE_MISS_REQ;
                    inv_pend_d = invalidate;
                end else if (if_req) begin
                    lookup_d = 1'b1;
                    tag_d    = if_tag;
                    idx_d    = if_idx;
                    off_d    = if_off;
                end
            end
            ICACHE_MISS_REQ: begin
                if (invalidate) inv_pend_d = 1'b1;
                if (mem_req_ready) begin
                    state_d = ICACHE_REFILL;
                    cnt_d   = '0;
                end
            end
            ICACHE_REFILL: begin
                if (invalidate) inv_pend_d = 1'b1;
                if (mem_resp_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ICACHE_REPLAY;
                        // A flush seen during the miss leaves the line invalid.
                        if (!(inv_pend_q || invalidate)) valid_d[idx_q] = 1'b1;
                    end
                end
            end
            ICACHE_REPLAY: begin
                state_d    = ICACHE_LOOKUP;
                lookup_d   = 1'b1;
                replay_d   = 1'b1;
                inv_pend_d = 1'b0;
            end
            default: state_d = ICACHE_LOOKUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ICACHE_LOOKUP;
            tag_q      <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= '0;
            lookup_q   <= 1'b0;
            replay_q   <= 1'b0;
            inv_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            off_q      <= off_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            lookup_q   <= lookup_d;
            replay_q   <= replay_d;
            inv_pend_q <= inv_pend_d;
        end
    end

    assign inst_valid    = lookup_q && (tag_match || replay_q);
    assign inst          = inst_valid ? data_rd : '0;
    assign cache_stall   = miss || (state_q != ICACHE_LOOKUP);
    assign mem_req_valid = (state_q == ICACHE_MISS_REQ);
    assign mem_req_addr  = mem_req_valid ? {tag_q, idx_q, {(OFF_W + 2){1'b0}}} : '0;

endmodule

// File: tb/tb_imem_cache.sv
// Bench for imem_cache: hit-sequence tables plus hand-driven miss/refill sequences,
// with fetched instructions checked against a queue of expected words.
module tb_imem_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_addr;
    logic        if_req;
    logic        invalidate;
    logic [31:0] inst;
    logic        inst_valid;
    logic        cache_stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;
    vec_t hit_tbl [6];

    imem_cache dut (
        .clk            (clk),
        .rst            (rst),
        .if_addr        (if_addr),
        .if_req         (if_req),
        .invalidate     (invalidate),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .cache_stall    (cache_stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    // Backing memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a[31:4] == 28'h4000000) w = 32'hA0 + 32'(a[3:2]);
        else                        w = a ^ 32'h1234_0000;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (inst_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL inst_unexpected: got inst_valid=1 inst=%h expected no delivery at %0t",
                         inst, $time);
            end else begin
                chk("inst", inst, exp_q.pop_front());
            end
        end
    end

    task automatic chk_idle_outputs(input string name);
        chk({name, "_flags"}, {29'd0, inst_valid, cache_stall, mem_req_valid}, 32'd0);
        chk({name, "_addr"}, mem_req_addr, 32'd0);
        chk({name, "_inst"}, inst, 32'd0);
    endtask

    task automatic run_hits(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(posedge clk); #1;
            if_req  = 1'b1;
            if_addr = hit_tbl[i].addr;
            exp_q.push_back(hit_tbl[i].data);
            #3 chk("hit_no_stall_no_req", {30'd0, cache_stall, mem_req_valid}, 32'd0);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        #3 chk("hit_drain", {30'd0, cache_stall, mem_req_valid}, 32'd0);
    endtask

    // Fetch that must miss; optional request backpressure, flush beat and reset beat.
    task automatic miss_fetch(input logic [31:0] a, input int delay, input int inv_beat,
                              input int rst_beat);
        logic [31:0] line;
        line = {a[31:4], 4'h0};
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = a;
        if (rst_beat < 0) exp_q.push_back(mem_word(a));
        #3 chk("pre_miss_stall", {31'd0, cache_stall}, 32'd0);
        @(posedge clk); #1;
        #3 chk("miss_detect", {29'd0, cache_stall, mem_req_valid, inst_valid}, 32'd4);
        for (int i = 0; i <= delay; i++) begin
            @(posedge clk); #1;
            mem_req_ready = (i == delay);
            #3;
            chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("req_addr", mem_req_addr, line);
            chk("req_stall", {30'd0, cache_stall, inst_valid}, 32'd2);
        end
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(line | (b * 4));
            invalidate     = (b == inv_beat);
            rst            = (b == rst_beat);
            if (b == rst_beat) if_req = 1'b0;
            #3;
            if (rst_beat >= 0 && b > rst_beat) chk_idle_outputs("after_rst");
            else chk("fill_stall", {29'd0, cache_stall, inst_valid, mem_req_valid}, 32'd4);
        end
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        invalidate     = 1'b0;
        rst            = 1'b0;
        if (rst_beat >= 0) begin
            if_req = 1'b0;
            #3 chk_idle_outputs("after_rst_late");
        end else begin
            #3 chk("replay_stall", {30'd0, cache_stall, inst_valid}, 32'd2);
            @(posedge clk); #1;
            if_req = 1'b0;
            #3 chk("deliver", {30'd0, cache_stall, inst_valid}, 32'd1);
        end
    endtask

    initial begin
        hit_tbl[0] = '{32'h4000_0000, 32'h0000_00A0};
        hit_tbl[1] = '{32'h4000_0004, 32'h0000_00A1};
        hit_tbl[2] = '{32'h4000_000C, 32'h0000_00A3};
        hit_tbl[3] = '{32'h4000_0008, 32'h0000_00A2};
        hit_tbl[4] = '{32'h4000_0404, 32'h5234_0404};
        hit_tbl[5] = '{32'h4000_000C, 32'h0000_00A3};

        rst            = 1'b1;
        if_addr        = '0;
        if_req         = 1'b0;
        invalidate     = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #3 chk_idle_outputs("reset");

        miss_fetch(32'h4000_0008, 0, -1, -1);
        run_hits(0, 3);

        miss_fetch(32'h4000_0400, 0, -1, -1);
        run_hits(4, 4);
        miss_fetch(32'h4000_0000, 5, -1, -1);
        run_hits(5, 5);

        // Flush on the result cycle: that hit is still delivered, the next fetch misses.
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = 32'h4000_0004;
        exp_q.push_back(32'h0000_00A1);
        @(posedge clk); #1;
        if_req     = 1'b0;
        invalidate = 1'b1;
        #3 chk("inv_same_cycle", {30'd0, inst_valid, cache_stall}, 32'd2);
        @(posedge clk); #1;
        invalidate = 1'b0;
        miss_fetch(32'h4000_0000, 0, -1, -1);

        miss_fetch(32'h4000_0010, 1, 1, -1);
        miss_fetch(32'h4000_0014, 0, -1, -1);

        miss_fetch(32'h4000_0020, 0, -1, 2);
        miss_fetch(32'h4000_0028, 2, -1, -1);

        @(posedge clk); #4;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
